rename_freelist_ctrl: RTL and testbench

//  Physical-register free-list controller for the 2-wide rename stage. Allocates up to two

---
 rtl/rename_freelist_ctrl_pkg.sv | 17 +
 rtl/rename_freelist_ctrl_if.sv | 38 +++
 rtl/rename_freelist_ctrl_fl_ptr_add.sv | 17 +
 rtl/rename_freelist_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rename_freelist_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_freelist_ctrl_pkg.sv
// Shared types and sizing for the rename free list.
// Tags are 6 bits; p0 is the reset mapping and never enters the list.
package rename_pkg;
  localparam int PHY_REG_NUM = 64;
  localparam int PHY_REG_SEL = $clog2(PHY_REG_NUM);
  localparam int DEPTH = PHY_REG_NUM - 1;
  localparam int CNT_W = PHY_REG_SEL + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef logic [PHY_REG_SEL-1:0] phy_reg_t;

  typedef enum logic [1:0] {
    FL_INIT,
    FL_RUN,
    FL_RECOVER
  } fl_state_t;
endpackage

// File: rtl/rename_freelist_ctrl_if.sv
// Rename/commit side bundle of the free-list controller.
// master = rename and commit logic, slave = free list.
interface rename_freelist_ctrl_if;
  import rename_pkg::*;

  logic             ren_valid;
  logic             need1;
  logic             need2;
  logic             ren_ready;
  phy_reg_t         phy_dst_1;
  phy_reg_t         phy_dst_2;
  logic             ret_alloc1;
  logic             ret_alloc2;
  logic             free_v1;
  logic             free_v2;
  phy_reg_t         free_reg1;
  phy_reg_t         free_reg2;
  logic             flush;
  logic [CNT_W-1:0] free_count;

  modport master (
    output ren_valid, need1, need2,
    output ret_alloc1, ret_alloc2,
    output free_v1, free_v2,
    output free_reg1, free_reg2, flush,
    input  ren_ready, phy_dst_1, phy_dst_2,
    input  free_count
  );

  modport slave (
    input  ren_valid, need1, need2,
    input  ret_alloc1, ret_alloc2,
    input  free_v1, free_v2,
    input  free_reg1, free_reg2, flush,
    output ren_ready, phy_dst_1, phy_dst_2,
    output free_count
  );
endinterface

// File: rtl/rename_freelist_ctrl_fl_ptr_add.sv
// Ring pointer adder: ptr + 0..2, wrapped modulo DEPTH.
// DEPTH is not a power of two, so wrap is compare-and-subtract.
module fl_ptr_add
  import rename_pkg::*;
(
  input  phy_reg_t   ptr,
  input  logic [1:0] inc,
  output phy_reg_t   sum
);
  logic [CNT_W-1:0] raw;
  phy_reg_t         wrap;

  assign raw  = {1'b0, ptr} + CNT_W'(inc);
  assign wrap = phy_reg_t'(raw - DEPTH_C);
  assign sum  = (raw >= DEPTH_C) ? wrap
                                 : raw[PHY_REG_SEL-1:0];
endmodule

// File: rtl/rename_freelist_ctrl.sv
// Physical-register free list for the 2-wide rename stage.
// Circular FIFO with speculative head, committed head and tail.
module rename_freelist_ctrl
  import rename_pkg::*;
(
  input logic clk,
  input logic reset,
  rename_freelist_ctrl_if.slave fl
);
  fl_state_t        state, state_nx;
  phy_reg_t         spec_head, commit_head;
  phy_reg_t         tail, init_idx;
  phy_reg_t         spec_adv, spec_nx;
  phy_reg_t         commit_nx, tail_nx;
  phy_reg_t         rd2_idx, wr2_idx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] diff, t7, c7;
  logic             full, full_nx, ring_full;
  logic             run, active, init_last;
  logic             fire, w1, w2;
  logic [1:0]       need_n, alloc_n;
  logic [1:0]       wr_n, ret_n;
  phy_reg_t         slots [DEPTH];

  assign run       = (state == FL_RUN);
  assign active    = (state != FL_INIT);
  assign init_last = (init_idx == phy_reg_t'(DEPTH - 1));

  assign need_n = {1'b0, fl.need1}
                + {1'b0, fl.need2};
  assign fl.ren_ready = run & ~fl.flush
                      & (count >= CNT_W'(need_n));
  assign fire    = fl.ren_valid & fl.ren_ready;
  assign alloc_n = fire ? need_n : 2'd0;

  // p0 is aliased by many arch regs, so its release is dropped
  assign w1 = active & fl.free_v1
            & (fl.free_reg1 != '0);
  assign w2 = active & fl.free_v2
            & (fl.free_reg2 != '0);
  assign wr_n  = {1'b0, w1} + {1'b0, w2};
  assign ret_n = active
               ? ({1'b0, fl.ret_alloc1}
                + {1'b0, fl.ret_alloc2})
               : 2'd0;

  fl_ptr_add u_rd2 (
    .ptr (spec_head),
    .inc ({1'b0, fl.need1}),
    .sum (rd2_idx)
  );

  fl_ptr_add u_spec (
    .ptr (spec_head),
    .inc (alloc_n),
    .sum (spec_adv)
  );

  fl_ptr_add u_commit (
    .ptr (commit_head),
    .inc (ret_n),
    .sum (commit_nx)
  );

  fl_ptr_add u_tail (
    .ptr (tail),
    .inc (wr_n),
    .sum (tail_nx)
  );

  fl_ptr_add u_wr2 (
    .ptr (tail),
    .inc ({1'b0, w1}),
    .sum (wr2_idx)
  );

  assign fl.phy_dst_1  = active ? slots[spec_head] : '0;
  assign fl.phy_dst_2  = active ? slots[rd2_idx] : '0;
  assign fl.free_count = count;

  // Committed ring span; equal pointers mean empty or full
  assign t7   = {1'b0, tail_nx};
  assign c7   = {1'b0, commit_nx};
  assign diff = (t7 >= c7) ? (t7 - c7)
                           : (t7 + DEPTH_C - c7);
  assign ring_full = (tail_nx == commit_nx)
                   & (full ? (wr_n >= ret_n)
                           : (wr_n > ret_n));

  always_comb begin
    state_nx = state;
    count_nx = count;
    full_nx  = full;
    spec_nx  = spec_adv;
    unique case (state)
      FL_INIT: begin
        if (init_last) begin
          state_nx = FL_RUN;
          count_nx = DEPTH_C;
          full_nx  = 1'b1;
        end
      end
      FL_RUN: begin
        full_nx  = ring_full;
        count_nx = count - CNT_W'(alloc_n)
                 + CNT_W'(wr_n);
        if (fl.flush) begin
          state_nx = FL_RECOVER;
          spec_nx  = commit_nx;
          count_nx = ring_full ? DEPTH_C : diff;
        end
      end
      FL_RECOVER: begin
        state_nx = FL_RUN;
        full_nx  = ring_full;
        count_nx = count + CNT_W'(wr_n);
      end
      default: state_nx = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FL_INIT;
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= '0;
      init_idx    <= '0;
      count       <= '0;
      full        <= 1'b0;
    end else begin
      state       <= state_nx;
      spec_head   <= spec_nx;
      commit_head <= commit_nx;
      tail        <= tail_nx;
      count       <= count_nx;
      full        <= full_nx;
      init_idx    <= (active || init_last)
                   ? '0 : init_idx + phy_reg_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!active) begin
      slots[init_idx] <= init_idx + phy_reg_t'(1);
    end else begin
      if (w1) slots[tail] <= fl.free_reg1;
      if (w2) slots[wr2_idx] <= fl.free_reg2;
    end
  end

  logic [CNT_W:0] cnt_sum, cnt_cap;
  assign cnt_sum = {1'b0, count}
                 + {{(CNT_W-1){1'b0}}, wr_n};
  assign cnt_cap = {1'b0, DEPTH_C}
                 + {{(CNT_W-1){1'b0}}, alloc_n};

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset)
    active |-> (cnt_sum <= cnt_cap));

  a_ring_bound: assert property (
    @(posedge clk) disable iff (reset)
    (active && full && tail == commit_head)
      |-> (wr_n <= ret_n));
endmodule

// File: tb/tb_rename_freelist_ctrl.sv
// Bench for the rename free list: FIFO model of free tags and
// in-flight allocations, expected tags queued per fire.
module tb_rename_freelist_ctrl;
  import rename_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rename_freelist_ctrl_if fl();

  rename_freelist_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl)
  );

  int       n_chk = 0;
  int       n_pass = 0;
  phy_reg_t fl_q[$];
  phy_reg_t inflight[$];
  phy_reg_t exp_q[$];
  bit       rec;
  bit       exp_rdy;
  phy_reg_t e;

  task automatic model_reset();
    fl_q.delete();
    inflight.delete();
    exp_q.delete();
    rec = 1'b0;
    for (int i = 1; i <= DEPTH; i++)
      fl_q.push_back(phy_reg_t'(i));
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(
    input bit v, n1, n2, f1,
    input phy_reg_t r1,
    input bit f2,
    input phy_reg_t r2,
    input bit ra1, ra2, fls);
    phy_reg_t t;
    fl.ren_valid  = v;
    fl.need1      = n1;
    fl.need2      = n2;
    fl.free_v1    = f1;
    fl.free_reg1  = r1;
    fl.free_v2    = f2;
    fl.free_reg2  = r2;
    fl.ret_alloc1 = ra1;
    fl.ret_alloc2 = ra2;
    fl.flush      = fls;
    exp_rdy = !fls && !rec
            && (fl_q.size() >= int'(n1) + int'(n2));
    if (v && exp_rdy) begin
      if (n1) begin
        t = fl_q.pop_front();
        exp_q.push_back(t);
        inflight.push_back(t);
      end
      if (n2) begin
        t = fl_q.pop_front();
        exp_q.push_back(t);
        inflight.push_back(t);
      end
    end
    if (f1 && r1 != 0) fl_q.push_back(r1);
    if (f2 && r2 != 0) fl_q.push_back(r2);
    if (ra1 && inflight.size() > 0) t = inflight.pop_front();
    if (ra2 && inflight.size() > 0) t = inflight.pop_front();
    if (fls) begin
      fl_q = {inflight, fl_q};
      inflight.delete();
    end
    rec = fls;
  endtask

  task automatic retire_all();
    while (inflight.size() > 0) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1'b1,
            inflight.size() >= 2, 0);
      next_cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    n_chk++;
    if (fl.ren_ready !== 1'b0)
      $display("FAIL rst_ready got=%b want=0", fl.ren_ready);
    else n_pass++;
    n_chk++;
    if (fl.free_count !== 7'd0)
      $display("FAIL rst_count got=%0d want=0", fl.free_count);
    else n_pass++;
    n_chk++;
    if (fl.phy_dst_1 !== 6'd0)
      $display("FAIL rst_dst1 got=%0d want=0", fl.phy_dst_1);
    else n_pass++;
    n_chk++;
    if (fl.phy_dst_2 !== 6'd0)
      $display("FAIL rst_dst2 got=%0d want=0", fl.phy_dst_2);
    else n_pass++;
  endtask

  task automatic wait_init(input string nm);
    int cyc = 0;
    reset = 1'b0;
    while (fl.ren_ready !== 1'b1 && cyc < 200) begin
      next_cyc();
      cyc++;
    end
    n_chk++;
    if (cyc != 63)
      $display("FAIL %s_cycles got=%0d want=63", nm, cyc);
    else n_pass++;
    n_chk++;
    if (fl.free_count !== 7'd63)
      $display("FAIL %s_count got=%0d want=63", nm, fl.free_count);
    else n_pass++;
    model_reset();
  endtask

  task automatic test_init_first();
    wait_init("init");
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (fl.ren_ready !== 1'b1)
      $display("FAIL first_ready got=%b want=1", fl.ren_ready);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_1 !== e || fl.phy_dst_1 !== 6'd1)
      $display("FAIL first_dst1 got=%0d want=1", fl.phy_dst_1);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e || fl.phy_dst_2 !== 6'd2)
      $display("FAIL first_dst2 got=%0d want=2", fl.phy_dst_2);
    else n_pass++;
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd61)
      $display("FAIL first_count got=%0d want=61", fl.free_count);
    else n_pass++;
  endtask

  task automatic test_drain();
    bit b;
    drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e || e !== 6'd3)
      $display("FAIL slot2_only got=%0d want=3", fl.phy_dst_2);
    else n_pass++;
    next_cyc();
    while (fl_q.size() > 1) begin
      b = fl_q.size() >= 3;
      drive(1, 1, b, 0, 0, 0, 0, 0, 0, 0);
      #1;
      n_chk++;
      if (fl.ren_ready !== exp_rdy)
        $display("FAIL drain_ready got=%b want=%b", fl.ren_ready, exp_rdy);
      else n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if (fl.phy_dst_1 !== e)
        $display("FAIL drain_dst1 got=%0d want=%0d", fl.phy_dst_1, e);
      else n_pass++;
      if (b) begin
        e = exp_q.pop_front();
        n_chk++;
        if (fl.phy_dst_2 !== e)
          $display("FAIL drain_dst2 got=%0d want=%0d", fl.phy_dst_2, e);
        else n_pass++;
      end
      next_cyc();
    end
    n_chk++;
    if (fl.free_count !== 7'd1)
      $display("FAIL drain_count got=%0d want=1", fl.free_count);
    else n_pass++;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (fl.ren_ready !== 1'b0)
      $display("FAIL short_ready got=%b want=0", fl.ren_ready);
    else n_pass++;
    next_cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.ren_ready !== 1'b1 || fl.phy_dst_1 !== e || e !== 6'd63)
      $display("FAIL last_dst got=%0d want=63", fl.phy_dst_1);
    else n_pass++;
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd0)
      $display("FAIL empty_count got=%0d want=0", fl.free_count);
    else n_pass++;
  endtask

  task automatic test_free_pair();
    retire_all();
    drive(0, 0, 0, 1, 6'd5, 1, 6'd9, 0, 0, 0);
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd2)
      $display("FAIL pair_count got=%0d want=2", fl.free_count);
    else n_pass++;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_1 !== e || e !== 6'd5)
      $display("FAIL pair_dst1 got=%0d want=5", fl.phy_dst_1);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e || e !== 6'd9)
      $display("FAIL pair_dst2 got=%0d want=9", fl.phy_dst_2);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_free_zero();
    drive(0, 0, 0, 1, 6'd0, 1, 6'd7, 0, 0, 0);
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd1)
      $display("FAIL p0_count got=%0d want=1", fl.free_count);
    else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_1 !== e || e !== 6'd7)
      $display("FAIL p0_dst got=%0d want=7", fl.phy_dst_1);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_flush();
    retire_all();
    for (int i = 1; i <= DEPTH; i += 2) begin
      drive(0, 0, 0, 1, phy_reg_t'(i), i + 1 <= DEPTH,
            phy_reg_t'(i + 1), 0, 0, 0);
      next_cyc();
    end
    n_chk++;
    if (fl.free_count !== 7'd63)
      $display("FAIL refill_count got=%0d want=63", fl.free_count);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (fl.phy_dst_1 !== e)
        $display("FAIL spec_dst1 got=%0d want=%0d", fl.phy_dst_1, e);
      else n_pass++;
      e = exp_q.pop_front();
      n_chk++;
      if (fl.phy_dst_2 !== e)
        $display("FAIL spec_dst2 got=%0d want=%0d", fl.phy_dst_2, e);
      else n_pass++;
      next_cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    next_cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    n_chk++;
    if (fl.ren_ready !== 1'b0)
      $display("FAIL flush_ready got=%b want=0", fl.ren_ready);
    else n_pass++;
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd59 || fl_q.size() != 59)
      $display("FAIL flush_count got=%0d want=59", fl.free_count);
    else n_pass++;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_chk++;
    if (fl.ren_ready !== 1'b0)
      $display("FAIL recover_ready got=%b want=0", fl.ren_ready);
    else n_pass++;
    next_cyc();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.ren_ready !== 1'b1 || fl.phy_dst_1 !== e || e !== 6'd5)
      $display("FAIL resume_dst got=%0d want=5", fl.phy_dst_1);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_back_to_back();
    bit b;
    while (fl_q.size() > 2) begin
      b = fl_q.size() >= 4;
      drive(1, 1, b, 0, 0, 0, 0, 0, 0, 0);
      #1;
      e = exp_q.pop_front();
      n_chk++;
      if (fl.phy_dst_1 !== e)
        $display("FAIL b2b_dst1 got=%0d want=%0d", fl.phy_dst_1, e);
      else n_pass++;
      if (b) e = exp_q.pop_front();
      next_cyc();
    end
    n_chk++;
    if (fl.free_count !== 7'd2)
      $display("FAIL b2b_pre got=%0d want=2", fl.free_count);
    else n_pass++;
    drive(1, 1, 1, 1, 6'd1, 1, 6'd2, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.ren_ready !== 1'b1 || fl.phy_dst_1 !== e)
      $display("FAIL b2b_dst1 got=%0d want=%0d", fl.phy_dst_1, e);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e)
      $display("FAIL b2b_dst2 got=%0d want=%0d", fl.phy_dst_2, e);
    else n_pass++;
    next_cyc();
    n_chk++;
    if (fl.free_count !== 7'd2)
      $display("FAIL b2b_count got=%0d want=2", fl.free_count);
    else n_pass++;
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_1 !== e || e !== 6'd1)
      $display("FAIL b2b_next1 got=%0d want=1", fl.phy_dst_1);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e || e !== 6'd2)
      $display("FAIL b2b_next2 got=%0d want=2", fl.phy_dst_2);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_reset_mid_init();
    reset = 1'b1;
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    reset = 1'b0;
    repeat (30) next_cyc();
    n_chk++;
    if (fl.ren_ready !== 1'b0 || fl.free_count !== 7'd0)
      $display("FAIL mid_init got=%b/%0d want=0/0", fl.ren_ready, fl.free_count);
    else n_pass++;
    reset = 1'b1;
    next_cyc();
    wait_init("reinit");
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_1 !== e || e !== 6'd1)
      $display("FAIL reinit_dst1 got=%0d want=1", fl.phy_dst_1);
    else n_pass++;
    e = exp_q.pop_front();
    n_chk++;
    if (fl.phy_dst_2 !== e || e !== 6'd2)
      $display("FAIL reinit_dst2 got=%0d want=2", fl.phy_dst_2);
    else n_pass++;
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_first();
    test_drain();
    test_free_pair();
    test_free_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
